soc_mem_resp: RTL and testbench

SOC_MEM_RESP -- requirements
Module: soc_mem_resp

---
 rtl/soc_mem_pkg.sv | 41 ++++
 rtl/soc_mem_resp_if.sv | 28 ++
 rtl/dpram_be.sv | 50 +++++
 rtl/soc_mem_resp.sv | 108 ++++++++++
 tb/tb_soc_mem_resp.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_mem_pkg.sv
// Shared constants, config-register decode and byte-merge helper for the SoC
// memory responder (RAM plus memory-mapped config registers).
package soc_mem_pkg;

  localparam logic [15:0] CONF_HI_DEF = 16'hBFAF;
  localparam logic [15:0] OFF_LED     = 16'hF020;
  localparam logic [15:0] OFF_SWITCH  = 16'hF030;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_SCRATCH = 16'h8000;

  typedef enum logic [2:0] {
    CR_NONE    = 3'd0,
    CR_LED     = 3'd1,
    CR_SWITCH  = 3'd2,
    CR_TIMER   = 3'd3,
    CR_SCRATCH = 3'd4
  } conf_reg_e;

  function automatic conf_reg_e conf_decode(input logic [15:0] off);
    conf_reg_e reg_sel;
    case (off)
      OFF_LED:     reg_sel = CR_LED;
      OFF_SWITCH:  reg_sel = CR_SWITCH;
      OFF_TIMER:   reg_sel = CR_TIMER;
      OFF_SCRATCH: reg_sel = CR_SCRATCH;
      default:     reg_sel = CR_NONE;
    endcase
    return reg_sel;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  we);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/soc_mem_resp_if.sv
// Instruction and data SRAM-style request/response ports of the memory responder.
interface soc_mem_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    input  inst_sram_rdata,
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata,
    output inst_sram_rdata,
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/dpram_be.sv
// Two-port byte-enabled RAM: read-first, registered read, port B wins per byte
// when both ports write the same word in the same cycle.
module dpram_be #(
  parameter int AW     = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic [DATA_W/8-1:0]   a_we,
  input  logic [AW-1:0]         a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  input  logic                  b_en,
  input  logic [DATA_W/8-1:0]   b_we,
  input  logic [AW-1:0]         b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  logic              w_same_word;

  assign w_same_word = (a_addr == b_addr);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (b_en && b_we[i]) begin
        r_mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
      if (a_en && a_we[i] && !(w_same_word && b_en && b_we[i])) begin
        r_mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // read stage p1: nonblocking read of r_mem gives read-first behaviour
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) a_rdata <= r_mem[a_addr];
      if (b_en) b_rdata <= r_mem[b_addr];
    end
  end

endmodule

// File: rtl/soc_mem_resp.sv
// Memory responder: shared RAM behind inst/data ports, plus LED, SWITCH, TIMER
// and SCRATCH config registers decoded from the data port.
module soc_mem_resp
  import soc_mem_pkg::*;
#(
  parameter int          RAM_AW  = 14,
  parameter logic [15:0] CONF_HI = CONF_HI_DEF
) (
  input  logic          clk,
  input  logic          reset,
  soc_mem_resp_if.slave bus,
  output logic [15:0]   led,
  input  logic [7:0]    switch
);

  logic        w_conf_sel;
  logic        w_conf_acc;
  logic        w_conf_wr;
  conf_reg_e   w_reg;
  logic [31:0] w_conf_rd;
  logic [31:0] w_led_merged;
  logic [31:0] w_timer_merged;
  logic [31:0] w_scratch_merged;
  logic [31:0] w_ram_b_rdata;
  logic        w_i_ram_en;
  logic        w_d_ram_en;
  logic        w_unused_addr_bits;

  logic [15:0] r_led;
  logic [31:0] r_timer;
  logic [31:0] r_scratch;
  logic [31:0] r_conf_rdata_p1;
  logic        r_sel_conf_p1;

  assign w_conf_sel = (bus.data_sram_addr[31:16] == CONF_HI);
  assign w_conf_acc = bus.data_sram_en & w_conf_sel;
  assign w_conf_wr  = w_conf_acc & (|bus.data_sram_we);
  assign w_reg      = conf_decode(bus.data_sram_addr[15:0]);

  // RAM enables are masked while reset is high so held requests cannot write
  assign w_i_ram_en = bus.inst_sram_en & ~reset;
  assign w_d_ram_en = bus.data_sram_en & ~w_conf_sel & ~reset;

  assign w_unused_addr_bits = ^{bus.inst_sram_addr[31:RAM_AW+2],
                                bus.inst_sram_addr[1:0]};

  dpram_be #(
    .AW     (RAM_AW),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .a_en    (w_i_ram_en),
    .a_we    (bus.inst_sram_we),
    .a_addr  (bus.inst_sram_addr[RAM_AW+1:2]),
    .a_wdata (bus.inst_sram_wdata),
    .a_rdata (bus.inst_sram_rdata),
    .b_en    (w_d_ram_en),
    .b_we    (bus.data_sram_we),
    .b_addr  (bus.data_sram_addr[RAM_AW+1:2]),
    .b_wdata (bus.data_sram_wdata),
    .b_rdata (w_ram_b_rdata)
  );

  assign w_led_merged     = byte_merge({16'h0000, r_led}, bus.data_sram_wdata, bus.data_sram_we);
  assign w_timer_merged   = byte_merge(r_timer, bus.data_sram_wdata, bus.data_sram_we);
  assign w_scratch_merged = byte_merge(r_scratch, bus.data_sram_wdata, bus.data_sram_we);

  always_comb begin
    w_conf_rd = 32'h0000_0000;
    case (w_reg)
      CR_LED:     w_conf_rd = {16'h0000, r_led};
      CR_SWITCH:  w_conf_rd = {24'h00_0000, switch};
      CR_TIMER:   w_conf_rd = r_timer;
      CR_SCRATCH: w_conf_rd = r_scratch;
      default:    w_conf_rd = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led     <= 16'h0000;
      r_timer   <= 32'h0000_0000;
      r_scratch <= 32'h0000_0000;
    end else begin
      if (w_conf_wr && (w_reg == CR_LED))     r_led     <= w_led_merged[15:0];
      if (w_conf_wr && (w_reg == CR_SCRATCH)) r_scratch <= w_scratch_merged;
      // a TIMER write replaces that cycle's increment
      if (w_conf_wr && (w_reg == CR_TIMER))   r_timer   <= w_timer_merged;
      else                                    r_timer   <= r_timer + 32'd1;
    end
  end

  // read stage p1: config read data and the data-port source select
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conf_rdata_p1 <= 32'h0000_0000;
      r_sel_conf_p1   <= 1'b0;
    end else begin
      if (bus.data_sram_en) r_sel_conf_p1   <= w_conf_sel;
      if (w_conf_acc)       r_conf_rdata_p1 <= w_conf_rd;
    end
  end

  assign bus.data_sram_rdata = r_sel_conf_p1 ? r_conf_rdata_p1 : w_ram_b_rdata;
  assign led                 = r_led;

endmodule

// File: tb/tb_soc_mem_resp.sv
// Randomized bench for soc_mem_resp against a transaction-level reference model.
module tb_soc_mem_resp;

  logic       clk = 1'b0;
  logic       reset;
  logic [15:0] led;
  logic [7:0]  sw;

  soc_mem_resp_if bif ();

  soc_mem_resp #(
    .RAM_AW  (14),
    .CONF_HI (16'hBFAF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bif.slave),
    .led    (led),
    .switch (sw)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_i_rd, m_d_rd, m_timer, m_scratch;
  logic [15:0] m_led;
  bit          m_i_known, m_d_known;

  logic [13:0] pool [8] = '{14'h0004, 14'h0008, 14'h0100, 14'h3FFF,
                            14'h0000, 14'h1234, 14'h2AAA, 14'h0555};
  logic [15:0] offs [5] = '{16'hF020, 16'hF030, 16'hE000, 16'h8000, 16'h0000};

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = we[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    bif.inst_sram_en = 1'b0; bif.inst_sram_we = 4'h0;
    bif.inst_sram_addr = 32'h0; bif.inst_sram_wdata = 32'h0;
    bif.data_sram_en = 1'b0; bif.data_sram_we = 4'h0;
    bif.data_sram_addr = 32'h0; bif.data_sram_wdata = 32'h0;
  endtask

  task automatic model_step();
    logic [31:0] t, tmp;
    int          iw, dw;
    bit          conf, twr;
    logic [15:0] off;
    if (reset) begin
      m_i_rd = 0; m_d_rd = 0; m_i_known = 1; m_d_known = 1;
      m_led = 0; m_timer = 0; m_scratch = 0;
      return;
    end
    t    = m_timer;
    twr  = 0;
    iw   = int'(bif.inst_sram_addr[15:2]);
    dw   = int'(bif.data_sram_addr[15:2]);
    conf = (bif.data_sram_addr[31:16] == 16'hBFAF);
    off  = bif.data_sram_addr[15:0];
    // reads see state before any of this cycle's writes
    if (bif.inst_sram_en) begin
      m_i_known = m_mem.exists(iw);
      if (m_i_known) m_i_rd = m_mem[iw];
    end
    if (bif.data_sram_en) begin
      if (conf) begin
        m_d_known = 1;
        if (off == 16'hF020)      m_d_rd = {16'h0, m_led};
        else if (off == 16'hF030) m_d_rd = {24'h0, sw};
        else if (off == 16'hE000) m_d_rd = t;
        else if (off == 16'h8000) m_d_rd = m_scratch;
        else                      m_d_rd = 32'h0;
      end else begin
        m_d_known = m_mem.exists(dw);
        if (m_d_known) m_d_rd = m_mem[dw];
      end
    end
    if (bif.inst_sram_en && bif.inst_sram_we != 0) begin
      tmp = m_mem.exists(iw) ? m_mem[iw] : 32'h0;
      m_mem[iw] = merge(tmp, bif.inst_sram_wdata, bif.inst_sram_we);
    end
    if (bif.data_sram_en && !conf && bif.data_sram_we != 0) begin
      tmp = m_mem.exists(dw) ? m_mem[dw] : 32'h0;
      m_mem[dw] = merge(tmp, bif.data_sram_wdata, bif.data_sram_we);
    end
    if (bif.data_sram_en && conf && bif.data_sram_we != 0) begin
      if (off == 16'hF020) begin
        tmp   = merge({16'h0, m_led}, bif.data_sram_wdata, bif.data_sram_we);
        m_led = tmp[15:0];
      end else if (off == 16'hE000) begin
        m_timer = merge(t, bif.data_sram_wdata, bif.data_sram_we);
        twr     = 1;
      end else if (off == 16'h8000) begin
        m_scratch = merge(m_scratch, bif.data_sram_wdata, bif.data_sram_we);
      end
    end
    if (!twr) m_timer = t + 32'd1;
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge clk);
    #1;
    if (m_i_known) check("inst_rdata", bif.inst_sram_rdata, m_i_rd);
    if (m_d_known) check("data_rdata", bif.data_sram_rdata, m_d_rd);
    check("led", {16'h0, led}, {16'h0, m_led});
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    set_idle();
    bif.data_sram_en = 1'b1; bif.data_sram_we = we;
    bif.data_sram_addr = a; bif.data_sram_wdata = d;
  endtask

  task automatic dread(input logic [31:0] a);
    set_idle();
    bif.data_sram_en = 1'b1; bif.data_sram_addr = a;
  endtask

  task automatic rand_inputs();
    logic [15:0] hi;
    logic [13:0] idx;
    set_idle();
    bif.inst_sram_en = 1'($urandom_range(0, 1));
    bif.inst_sram_we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    idx = pool[$urandom_range(0, 7)];
    bif.inst_sram_addr  = {16'($urandom), idx, 2'($urandom)};
    bif.inst_sram_wdata = $urandom;
    bif.data_sram_en = 1'($urandom_range(0, 1));
    bif.data_sram_we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
    bif.data_sram_wdata = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      bif.data_sram_addr = {16'hBFAF, offs[$urandom_range(0, 4)]};
    end else begin
      hi = 16'($urandom);
      if (hi == 16'hBFAF) hi = 16'h0000;
      idx = pool[$urandom_range(0, 7)];
      bif.data_sram_addr = {hi, idx, 2'($urandom)};
    end
    if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    set_idle();
    m_i_known = 1; m_d_known = 1;
    m_i_rd = 0; m_d_rd = 0; m_led = 0; m_timer = 0; m_scratch = 0;
    do_cycle();
    do_cycle();
    check("rst_inst_rdata", bif.inst_sram_rdata, 32'h0);
    check("rst_data_rdata", bif.data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    reset = 1'b0;

    dwrite(32'h0000_0010, 32'h1234_5678, 4'hF); do_cycle();
    dread(32'h0000_0010);                       do_cycle();
    check("wr_rd_data", bif.data_sram_rdata, 32'h1234_5678);
    set_idle(); bif.inst_sram_en = 1'b1; bif.inst_sram_addr = 32'h0000_0010; do_cycle();
    check("inst_rd", bif.inst_sram_rdata, 32'h1234_5678);
    check("data_hold", bif.data_sram_rdata, 32'h1234_5678);

    dwrite(32'h0000_0010, 32'hAABB_CCDD, 4'b0010);
    bif.inst_sram_en = 1'b1; bif.inst_sram_addr = 32'h0000_0010; do_cycle();
    check("read_first_inst", bif.inst_sram_rdata, 32'h1234_5678);
    dread(32'h0000_0010); do_cycle();
    check("byte_we", bif.data_sram_rdata, 32'h1234_CC78);

    dwrite(32'h0000_0020, 32'h2222_2222, 4'b0011);
    bif.inst_sram_en = 1'b1; bif.inst_sram_we = 4'hF;
    bif.inst_sram_addr = 32'h0000_0020; bif.inst_sram_wdata = 32'h1111_1111; do_cycle();
    dread(32'h0000_0020); do_cycle();
    check("dual_wr_prio", bif.data_sram_rdata, 32'h1111_2222);

    dwrite(32'hBFAF_F020, 32'hFFFF_5A5A, 4'hF); do_cycle();
    check("led_wr", {16'h0, led}, 32'h0000_5A5A);
    dread(32'hBFAF_F020); do_cycle();
    check("led_rd", bif.data_sram_rdata, 32'h0000_5A5A);
    sw = 8'hC3;
    dwrite(32'hBFAF_F030, 32'hFFFF_FFFF, 4'hF); do_cycle();
    dread(32'hBFAF_F030); do_cycle();
    check("switch_rd", bif.data_sram_rdata, 32'h0000_00C3);
    dread(32'hBFAF_1234); do_cycle();
    check("unmapped_rd", bif.data_sram_rdata, 32'h0);
    dwrite(32'hBFAF_8000, 32'hDEAD_BEEF, 4'hF); do_cycle();
    dread(32'hBFAF_8000); do_cycle();
    check("scratch_rd", bif.data_sram_rdata, 32'hDEAD_BEEF);

    dwrite(32'hBFAF_E000, 32'h0000_0100, 4'hF); do_cycle();
    set_idle(); do_cycle(); do_cycle(); do_cycle();
    dread(32'hBFAF_E000); do_cycle();
    check("timer_load", bif.data_sram_rdata, 32'h0000_0103);

    // burst of mixed traffic, then reset raised between clock edges
    dwrite(32'h0000_0020, 32'h3333_3333, 4'hF);
    bif.inst_sram_en = 1'b1; bif.inst_sram_addr = 32'h0000_0010; do_cycle();
    dread(32'hBFAF_F020); bif.inst_sram_en = 1'b1; bif.inst_sram_addr = 32'h0000_0020; do_cycle();
    dwrite(32'h0000_0010, 32'h9999_9999, 4'hF);
    #2 reset = 1'b1;
    #1;
    check("async_inst_rdata", bif.inst_sram_rdata, 32'h0);
    check("async_data_rdata", bif.data_sram_rdata, 32'h0);
    check("async_led", {16'h0, led}, 32'h0);
    do_cycle();
    reset = 1'b0;
    dread(32'hBFAF_E000); do_cycle();
    check("timer_after_rst", bif.data_sram_rdata, 32'h0);
    dread(32'h0000_0010); do_cycle();
    check("ram_kept", bif.data_sram_rdata, 32'h1234_CC78);

    for (int k = 0; k < 8; k++) begin
      dwrite({16'h0, pool[k], 2'b00}, $urandom, 4'hF); do_cycle();
    end
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      rand_inputs();
      do_cycle();
    end
    reset = 1'b0;
    set_idle();
    do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
